// File: rtl/data_island_assembler.sv
// Data-island packet assembler: two-slot packet buffer feeding a 9-bit per-pixel stream with BCH ECC.
// Optional statistics counters are built only when DATA_ISLAND_ASSEMBLER_STATS_EN is defined.
module data_island_assembler #(
  parameter int          MAX_PACKETS = 18,
  parameter logic [7:0]  ECC_POLY    = 8'b10000011
) (
  input  logic         clk_pixel,
  input  logic         reset,
  input  logic         data_island_period,
  input  logic         pkt_valid,
  output logic         pkt_ready,
  input  logic [23:0]  pkt_header,
  input  logic [223:0] pkt_sub,
  output logic [8:0]   packet_data,
  output logic [4:0]   counter,
  output logic [4:0]   packet_index,
  output logic         island_overrun,
  output logic         island_truncated,
  output logic [15:0]  packets_sent,
  output logic [15:0]  nulls_sent
);

  localparam logic [4:0] LAST_INDEX = 5'(MAX_PACKETS - 1);

  logic             hold_valid, active_valid;
  logic [23:0]      hold_header, active_header;
  logic [3:0][55:0] hold_sub, active_sub;
  logic [4:0]       counter_q, packet_index_q;
  logic [7:0]       header_ecc;
  logic [3:0][7:0]  sub_ecc;
  logic [5:0]       pair_lo, pair_hi;
  logic             load, transfer, finish, truncate;

  function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic b);
    return (ecc >> 1) ^ ((ecc[0] ^ b) ? ECC_POLY : 8'h00);
  endfunction

  // Handshake: a packet moves into the hold slot on any clk_pixel edge where
  // pkt_valid && pkt_ready; upstream keeps pkt_valid and payload stable until
  // then. pkt_ready depends only on the hold slot being empty.
  assign pkt_ready = !hold_valid;
  assign load      = pkt_valid && pkt_ready;
  assign finish    = data_island_period && (counter_q == 5'd31);
  assign truncate  = !data_island_period && (counter_q != 5'd0);
  assign transfer  = hold_valid && ((!data_island_period && !active_valid) || finish);

  assign pair_lo = {counter_q, 1'b0};
  assign pair_hi = {counter_q, 1'b1};

  // counter_q only holds a nonzero value outside an island on the first idle cycle
  assign counter      = data_island_period ? counter_q : 5'd0;
  assign packet_index = data_island_period ? packet_index_q : 5'd0;

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      hold_valid       <= 1'b0;
      active_valid     <= 1'b0;
      hold_header      <= '0;
      hold_sub         <= '0;
      active_header    <= '0;
      active_sub       <= '0;
      counter_q        <= '0;
      packet_index_q   <= '0;
      header_ecc       <= '0;
      sub_ecc          <= '0;
      island_overrun   <= 1'b0;
      island_truncated <= 1'b0;
    end else begin
      island_overrun   <= 1'b0;
      island_truncated <= 1'b0;

      if (data_island_period) begin
        counter_q <= counter_q + 5'd1;
        if (counter_q == 5'd31) begin
          header_ecc <= '0;
          sub_ecc    <= '0;
          if (packet_index_q == LAST_INDEX) island_overrun <= 1'b1;
          else packet_index_q <= packet_index_q + 5'd1;
        end else begin
          if (counter_q < 5'd24)
            header_ecc <= bch_step(header_ecc, active_header[counter_q]);
          if (counter_q < 5'd28)
            for (int k = 0; k < 4; k++)
              sub_ecc[k] <= bch_step(bch_step(sub_ecc[k], active_sub[k][pair_lo]),
                                     active_sub[k][pair_hi]);
        end
      end else begin
        counter_q      <= '0;
        packet_index_q <= '0;
        header_ecc     <= '0;
        sub_ecc        <= '0;
        if (truncate) island_truncated <= 1'b1;
      end

      if (load) begin
        hold_header <= pkt_header;
        hold_sub    <= pkt_sub;
      end
      if (load) hold_valid <= 1'b1;
      else if (transfer) hold_valid <= 1'b0;

      // A finished or truncated packet leaves zeros behind so the next slot is a null packet
      if (transfer) begin
        active_valid  <= 1'b1;
        active_header <= hold_header;
        active_sub    <= hold_sub;
      end else if (finish || truncate) begin
        active_valid  <= 1'b0;
        active_header <= '0;
        active_sub    <= '0;
      end
    end
  end

  always_comb begin
    packet_data = '0;
    if (data_island_period) begin
      packet_data[0] = (counter_q < 5'd24) ? active_header[counter_q] : header_ecc[counter_q[2:0]];
      for (int k = 0; k < 4; k++) begin
        if (counter_q < 5'd28) begin
          packet_data[1+k] = active_sub[k][pair_lo];
          packet_data[5+k] = active_sub[k][pair_hi];
        end else begin
          packet_data[1+k] = sub_ecc[k][{counter_q[1:0], 1'b0}];
          packet_data[5+k] = sub_ecc[k][{counter_q[1:0], 1'b1}];
        end
      end
    end
  end

`ifdef DATA_ISLAND_ASSEMBLER_STATS_EN
  logic [15:0] packets_q, nulls_q;

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      packets_q <= '0;
      nulls_q   <= '0;
    end else if (finish) begin
      if (active_valid && packets_q != 16'hFFFF) packets_q <= packets_q + 16'd1;
      if (!active_valid && nulls_q != 16'hFFFF) nulls_q <= nulls_q + 16'd1;
    end
  end

  assign packets_sent = packets_q;
  assign nulls_sent   = nulls_q;
`else
  assign packets_sent = 16'd0;
  assign nulls_sent   = 16'd0;
`endif

endmodule
